demux_router: RTL

DEMUX_ROUTER -- requirements
Module: demux_router

---
 rtl/demux_router.sv | 132 +++++++++++++
 1 files changed

// File: rtl/demux_router.sv
// ---------------------------------------------------------------------------
// demux_router
//   Accepts {sel, data} words through a 2-entry in-order input FIFO and
//   delivers each word to one of four registered output slots chosen by sel.
//   Each slot has its own valid/ready handshake and an 8-bit wrapping counter
//   of delivered words.
//
// Ports
//   clk                 clock, all state changes on the rising edge
//   rst_n               asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_data, in_sel     payload and destination index (sampled on handshake)
//   out_valid[3:0]      slot k holds a word
//   out_ready[3:0]      consumer k takes the word
//   out_data0..3        slot payloads
//   fifo_count          input FIFO occupancy (0..2)
//   route_cnt0..3       words delivered per output, wraps at 256
// ---------------------------------------------------------------------------
module demux_router #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [1:0]       fifo_count,
    output logic [7:0]       route_cnt0,
    output logic [7:0]       route_cnt1,
    output logic [7:0]       route_cnt2,
    output logic [7:0]       route_cnt3
);

    // FIFO entry layout: {sel, data}
    logic [WIDTH+1:0] fifo_mem_reg [2];
    logic             rd_ptr_reg;
    logic             wr_ptr_reg;
    logic [1:0]       count_reg;

    logic             slot_valid_reg [4];
    logic [WIDTH-1:0] slot_data_reg  [4];
    logic [7:0]       route_cnt_reg  [4];

    logic [WIDTH+1:0] head;
    logic [1:0]       head_sel;
    logic             push;
    logic             dispatch;
    logic             slot_free [4];

    assign in_ready = (count_reg != 2'd2);
    assign push     = in_valid && in_ready;
    assign head     = fifo_mem_reg[rd_ptr_reg];
    assign head_sel = head[WIDTH+1:WIDTH];

    // A slot can take the head if empty or being drained at this same edge.
    // Only the head is ever considered, so a stalled head blocks every slot.
    always_comb begin
        dispatch = 1'b0;
        if (count_reg != 2'd0) begin
            dispatch = slot_free[head_sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem_reg[0] <= '0;
            fifo_mem_reg[1] <= '0;
            rd_ptr_reg      <= 1'b0;
            wr_ptr_reg      <= 1'b0;
            count_reg       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem_reg[wr_ptr_reg] <= {in_sel, in_data};
                wr_ptr_reg               <= ~wr_ptr_reg;
            end
            if (dispatch) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, dispatch};
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            logic hit;
            logic take;

            assign slot_free[gi] = !slot_valid_reg[gi] || out_ready[gi];
            assign hit           = dispatch && (head_sel == 2'(gi));
            assign take          = slot_valid_reg[gi] && out_ready[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_valid_reg[gi] <= 1'b0;
                    slot_data_reg[gi]  <= '0;
                    route_cnt_reg[gi]  <= 8'd0;
                end else begin
                    // Refill wins over clear so a draining slot stays valid.
                    if (hit) begin
                        slot_valid_reg[gi] <= 1'b1;
                        slot_data_reg[gi]  <= head[WIDTH-1:0];
                    end else if (take) begin
                        slot_valid_reg[gi] <= 1'b0;
                    end
                    if (take) begin
                        route_cnt_reg[gi] <= route_cnt_reg[gi] + 8'd1;
                    end
                end
            end

            assign out_valid[gi] = slot_valid_reg[gi];
        end
    endgenerate

    assign fifo_count = count_reg;
    assign out_data0  = slot_data_reg[0];
    assign out_data1  = slot_data_reg[1];
    assign out_data2  = slot_data_reg[2];
    assign out_data3  = slot_data_reg[3];
    assign route_cnt0 = route_cnt_reg[0];
    assign route_cnt1 = route_cnt_reg[1];
    assign route_cnt2 = route_cnt_reg[2];
    assign route_cnt3 = route_cnt_reg[3];

endmodule
